color_blob_tracker: RTL



---
 rtl/tracker_pkg.sv | 24 ++
 rtl/axis_extent.sv | 54 +++++
 rtl/color_blob_tracker.sv | 229 ++++++++++++++++++++++
 3 files changed

// File: rtl/tracker_pkg.sv
// tracker_pkg: shared widths, FSM state encoding and the midpoint helper
// used by color_blob_tracker and axis_extent.
package tracker_pkg;

    localparam int COORD_W = 10;
    localparam int ADDR_W  = 20;
    localparam int PIX_W   = 8;

    typedef enum logic [1:0] {
        SYNC   = 2'd0,
        ACCUM  = 2'd1,
        REPORT = 2'd2
    } state_e;

    // Midpoint of two coordinates. The sum is formed one bit wider so the
    // carry survives before the halving shift.
    function automatic logic [COORD_W-1:0] mid(input logic [COORD_W-1:0] a,
                                               input logic [COORD_W-1:0] b);
        logic [COORD_W:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[COORD_W:1];
    endfunction

endpackage

// File: rtl/axis_extent.sv
// axis_extent: running min/max of one coordinate across a frame.
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clear_i       zero both extents (start of a new frame)
//   first_i       the next update is the first marked pixel of the frame
//   update_i      fold value_i into the extents this cycle
//   value_i       coordinate of the current pixel
//   min_o, max_o  current extents
module axis_extent
    import tracker_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               clear_i,
    input  logic               first_i,
    input  logic               update_i,
    input  logic [COORD_W-1:0] value_i,
    output logic [COORD_W-1:0] min_o,
    output logic [COORD_W-1:0] max_o
);

    logic [COORD_W-1:0] min_q, min_d;
    logic [COORD_W-1:0] max_q, max_d;

    always_comb begin
        min_d = min_q;
        max_d = max_q;
        // A first update loads directly, so stale extents from an earlier
        // frame never leak into the comparison.
        if (update_i && first_i) begin
            min_d = value_i;
            max_d = value_i;
        end else if (clear_i) begin
            min_d = '0;
            max_d = '0;
        end else if (update_i) begin
            if (value_i < min_q) min_d = value_i;
            if (value_i > max_q) max_d = value_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            min_q <= '0;
            max_q <= '0;
        end else begin
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign min_o = min_q;
    assign max_o = max_q;

endmodule

// File: rtl/color_blob_tracker.sv
// color_blob_tracker: per-frame bounding box, midpoint and count of marked
// pixels (pixel_in >= MARK_THRESH) from a row-major capture write stream.
//   pclk, reset          clock, asynchronous active-high reset
//   pixel_valid          one pixel on pixel_addr/pixel_in this cycle
//   report_valid         one-cycle pulse when a frame's results update
//   object_found         last report had mark_count >= MIN_COUNT
//   x_min..y_max, cx, cy bounding box and midpoint (0 when not found)
//   mark_count           marked pixels in the last reported frame
//   frame_error          sticky address-discontinuity flag, cleared by report
// Optional: define TRACKER_SMOOTH_EN to average each found midpoint with the
// previously reported one.
module color_blob_tracker
    import tracker_pkg::*;
#(
    parameter int                H_RES       = 640,
    parameter int                V_RES       = 480,
    parameter logic [PIX_W-1:0]  MARK_THRESH = 8'd255,
    parameter logic [ADDR_W-1:0] MIN_COUNT   = 20'd16
) (
    input  logic               pclk,
    input  logic               reset,
    input  logic               pixel_valid,
    input  logic [ADDR_W-1:0]  pixel_addr,
    input  logic [PIX_W-1:0]   pixel_in,
    output logic               report_valid,
    output logic               object_found,
    output logic [COORD_W-1:0] x_min,
    output logic [COORD_W-1:0] x_max,
    output logic [COORD_W-1:0] y_min,
    output logic [COORD_W-1:0] y_max,
    output logic [COORD_W-1:0] cx,
    output logic [COORD_W-1:0] cy,
    output logic [ADDR_W-1:0]  mark_count,
    output logic               frame_error
);

    localparam logic [ADDR_W-1:0]  LAST_ADDR = ADDR_W'(H_RES * V_RES - 1);
    localparam logic [COORD_W-1:0] COL_LAST  = COORD_W'(H_RES - 1);

    state_e              state_q, state_d;
    logic [COORD_W-1:0]  col_q, col_d, row_q, row_d;
    logic [ADDR_W-1:0]   exp_addr_q, exp_addr_d;
    logic [ADDR_W-1:0]   mark_acc_q, mark_acc_d;
    logic                frame_error_q, frame_error_d;

    logic                report_valid_q, report_valid_d;
    logic                found_q, found_d;
    logic [COORD_W-1:0]  x_min_q, x_min_d, x_max_q, x_max_d;
    logic [COORD_W-1:0]  y_min_q, y_min_d, y_max_q, y_max_d;
    logic [COORD_W-1:0]  cx_q, cx_d, cy_q, cy_d;
    logic [ADDR_W-1:0]   count_q, count_d;

    // start: pixel at address 0 opens a fresh frame; take: in-sequence pixel
    logic                start, take;
    logic                marked;
    logic [COORD_W-1:0]  col_cur, row_cur;
    logic [ADDR_W-1:0]   acc_cur;
    logic                ext_clear, ext_first, ext_update;
    logic [COORD_W-1:0]  x_lo, x_hi, y_lo, y_hi;
    logic [COORD_W-1:0]  raw_cx, raw_cy;

    assign marked = (pixel_in >= MARK_THRESH);
    assign raw_cx = mid(x_lo, x_hi);
    assign raw_cy = mid(y_lo, y_hi);

    always_comb begin
        state_d        = state_q;
        col_d          = col_q;
        row_d          = row_q;
        exp_addr_d     = exp_addr_q;
        mark_acc_d     = mark_acc_q;
        frame_error_d  = frame_error_q;
        report_valid_d = 1'b0;
        found_d        = found_q;
        x_min_d        = x_min_q;
        x_max_d        = x_max_q;
        y_min_d        = y_min_q;
        y_max_d        = y_max_q;
        cx_d           = cx_q;
        cy_d           = cy_q;
        count_d        = count_q;
        start          = 1'b0;
        take           = 1'b0;

        unique case (state_q)
            SYNC: begin
                start = pixel_valid && (pixel_addr == '0);
            end
            ACCUM: begin
                if (pixel_valid) begin
                    if (pixel_addr == '0) begin
                        start = 1'b1;
                    end else if (pixel_addr == exp_addr_q) begin
                        take = 1'b1;
                    end else begin
                        frame_error_d = 1'b1;
                        state_d       = SYNC;
                    end
                end
            end
            REPORT: begin
                // Accumulators still hold the finished frame this cycle; a new
                // frame starting now only affects their next values.
                state_d        = SYNC;
                start          = pixel_valid && (pixel_addr == '0);
                report_valid_d = 1'b1;
                frame_error_d  = 1'b0;
                found_d        = (mark_acc_q >= MIN_COUNT);
                count_d        = mark_acc_q;
                if (found_d) begin
                    x_min_d = x_lo;
                    x_max_d = x_hi;
                    y_min_d = y_lo;
                    y_max_d = y_hi;
`ifdef TRACKER_SMOOTH_EN
                    // The output registers double as history: found_q/cx_q
                    // describe the previous report.
                    cx_d = found_q ? mid(cx_q, raw_cx) : raw_cx;
                    cy_d = found_q ? mid(cy_q, raw_cy) : raw_cy;
`else
                    cx_d = raw_cx;
                    cy_d = raw_cy;
`endif
                end else begin
                    x_min_d = '0;
                    x_max_d = '0;
                    y_min_d = '0;
                    y_max_d = '0;
                    cx_d    = '0;
                    cy_d    = '0;
                end
            end
            default: state_d = SYNC;
        endcase

        // A starting pixel sees cleared counters, then is processed normally.
        col_cur = start ? '0 : col_q;
        row_cur = start ? '0 : row_q;
        acc_cur = start ? '0 : mark_acc_q;

        ext_clear  = start;
        ext_first  = (acc_cur == '0);
        ext_update = (start || take) && marked;

        if (start || take) begin
            mark_acc_d = acc_cur;
            if (marked && (acc_cur != '1)) mark_acc_d = acc_cur + 1'b1;
            if (col_cur == COL_LAST) begin
                col_d = '0;
                row_d = row_cur + 1'b1;
            end else begin
                col_d = col_cur + 1'b1;
                row_d = row_cur;
            end
            exp_addr_d = (start ? '0 : exp_addr_q) + 1'b1;
            state_d    = (pixel_addr == LAST_ADDR) ? REPORT : ACCUM;
        end
    end

    axis_extent u_x_extent (
        .clk_i    (pclk),
        .rst_i    (reset),
        .clear_i  (ext_clear),
        .first_i  (ext_first),
        .update_i (ext_update),
        .value_i  (col_cur),
        .min_o    (x_lo),
        .max_o    (x_hi)
    );

    axis_extent u_y_extent (
        .clk_i    (pclk),
        .rst_i    (reset),
        .clear_i  (ext_clear),
        .first_i  (ext_first),
        .update_i (ext_update),
        .value_i  (row_cur),
        .min_o    (y_lo),
        .max_o    (y_hi)
    );

    always_ff @(posedge pclk or posedge reset) begin
        if (reset) begin
            state_q        <= SYNC;
            col_q          <= '0;
            row_q          <= '0;
            exp_addr_q     <= '0;
            mark_acc_q     <= '0;
            frame_error_q  <= 1'b0;
            report_valid_q <= 1'b0;
            found_q        <= 1'b0;
            x_min_q        <= '0;
            x_max_q        <= '0;
            y_min_q        <= '0;
            y_max_q        <= '0;
            cx_q           <= '0;
            cy_q           <= '0;
            count_q        <= '0;
        end else begin
            state_q        <= state_d;
            col_q          <= col_d;
            row_q          <= row_d;
            exp_addr_q     <= exp_addr_d;
            mark_acc_q     <= mark_acc_d;
            frame_error_q  <= frame_error_d;
            report_valid_q <= report_valid_d;
            found_q        <= found_d;
            x_min_q        <= x_min_d;
            x_max_q        <= x_max_d;
            y_min_q        <= y_min_d;
            y_max_q        <= y_max_d;
            cx_q           <= cx_d;
            cy_q           <= cy_d;
            count_q        <= count_d;
        end
    end

    assign report_valid = report_valid_q;
    assign object_found = found_q;
    assign x_min        = x_min_q;
    assign x_max        = x_max_q;
    assign y_min        = y_min_q;
    assign y_max        = y_max_q;
    assign cx           = cx_q;
    assign cy           = cy_q;
    assign mark_count   = count_q;
    assign frame_error  = frame_error_q;

endmodule
